mmio_mailbox: RTL and testbench
===============================

Name: mmio_mailbox

Overview:
- Memory-mapped mailbox peripheral and responder on the CPU data-memory bus: ce, we, addr, sel, write data, read data.
- Sits beside the data RAM in the SOPC; the top decodes which responder drives the CPU read data.
- Holds two FIFOs:
  - TX FIFO: the CPU writes words; an external consumer drains them over a valid/ready port.
  - RX FIFO: an external producer fills it over a valid/ready port; the CPU reads words out.
- Provides a level interrupt on RX data available.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of the 16-byte register window; addr[31:4] compared against BASE_ADDR[31:4].
- DEPTH, 8, entries per FIFO; must be a power of two.
- AW, 3, log2(DEPTH); counters are AW+1 bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- ce  in  1  bus access valid
- we  in  1  1 = write, 0 = read
- addr  in  32  byte address; addr[3:2] selects the register
- sel  in  4  byte enables, bit n covers data[8n+7:8n]
- data_i  in  32  CPU write data
- data_o  out  32  CPU read data, combinational
- out_data  out  32  TX FIFO head
- out_valid  out  1  TX FIFO non-empty
- out_ready  in  1  consumer accepts the head
- in_data  in  32  producer word
- in_valid  in  1  producer word valid
- in_ready  out  1  RX FIFO not full
- irq  out  1  irq_en AND RX FIFO non-empty

Behaviour:
- Hit decode: hit = ce AND addr[31:4]==BASE_ADDR[31:4]. Write = hit AND we AND sel!=0. Read = hit AND NOT we.
- Register map:
  - 0x0 TXDATA: write only, reads 0.
  - 0x4 RXDATA: read only, read pops.
  - 0x8 STATUS: read only.
  - 0xC CTRL: write only, reads {27'b0, irq_en, 4'b0}.
- TXDATA write: pushes data_i with disabled bytes forced to 0.
  - If tx_count==DEPTH, the word is dropped and sticky tx_drop is set.
  - A consumer pop in the same cycle does not free space for the push.
- RXDATA read: data_o = RX head.
  - If RX is non-empty, the pop takes effect at the clock edge ending the access; one pop per access cycle.
  - If RX is empty: data_o = 0, no pop, sticky rx_underflow is set.
- STATUS read: data_o = {tx_count zero-extended to 8 bits, rx_count zero-extended to 8 bits, 11'b0, irq_en, rx_underflow, tx_drop, tx_full, rx_nonempty} (bits 31:24, 23:16, 15:5, 4, 3, 2, 1, 0).
- CTRL write (byte 0 only, only if sel[0]=1):
  - bit0: flush TX.
  - bit1: flush RX.
  - bit2: loads irq_en.
  - bit3: write-1 clears tx_drop.
  - bit4: write-1 clears rx_underflow.
- data_o = 0 whenever there is no read hit.
- TX drain: out_valid = tx_count!=0; out_data = mem[tx_rd_ptr]. A pop happens when out_valid AND out_ready.
- RX fill: in_ready = rx_count!=DEPTH. A push happens when in_valid AND in_ready; a same-cycle CPU pop does not raise in_ready.
- Counts: a simultaneous push and pop on one FIFO leaves the count unchanged and advances both pointers. Pointers are AW bits and wrap modulo DEPTH.
- Flush priority: a flush clears that FIFO's pointers and count and overrides any same-cycle push or pop on that FIFO; the pushed word is lost.
- A sticky set and a W1C clear in the same cycle leaves the sticky bit set.
- Reset (asynchronous, any cycle, including mid-access or mid-handshake):
  - pointers, counts, stickies and irq_en return to 0;
  - out_valid=0, in_ready=1, irq=0;
  - FIFO storage is not reset; out_data is don't-care while out_valid=0.
- Latency:
  - CPU write becomes visible on out_valid the next cycle.
  - Producer push becomes visible on STATUS and irq the next cycle.
  - Reads are zero-wait.

Test Plan:
- Reset, write TXDATA 0xDEADBEEF with sel=1111, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF; one cycle later out_valid=0.
- Write TXDATA with sel=0011, data 0x12345678 -> out_data=0x00005678.
- 9 TX writes with out_ready=0, DEPTH=8 -> STATUS=0x0800_0006 (tx_count=8, tx_full, tx_drop); drain yields 8 words in order, 9th absent; CTRL write 0x08 clears tx_drop.
- Producer pushes 0xA1, 0xA2 with irq_en=1 -> irq=1, STATUS[23:16]=2; RXDATA reads return 0xA1 then 0xA2; irq drops after the second pop.
- RXDATA read when empty -> data_o=0, STATUS bit3=1; simultaneous producer push and CPU pop with rx_count=3 -> rx_count stays 3.
- Fill RX to 8 (in_ready=0), assert rst mid-cycle -> in_ready=1, irq=0, STATUS=0 immediately; TX flush in the same cycle as a TXDATA write -> tx_count=0.

Source files
------------

// File: rtl/mmio_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : mmio_mailbox
// Purpose  : CPU-bus mailbox with a TX FIFO (CPU -> consumer), an RX FIFO
//            (producer -> CPU), sticky error flags and an RX-available irq.
// Revision : 1.0  initial release
// ============================================================================
module mmio_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 8,
  parameter int          AW        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        irq
);

  localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
  localparam logic [1:0]  REG_TX    = 2'd0;
  localparam logic [1:0]  REG_RX    = 2'd1;
  localparam logic [1:0]  REG_STAT  = 2'd2;
  localparam logic [1:0]  REG_CTRL  = 2'd3;

  // FIFO storage (not reset)
  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];

  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   tx_count, rx_count;
  logic          tx_drop, rx_underflow, irq_en;

  logic          hit, bus_wr, bus_rd;
  logic [1:0]    rsel;
  logic [31:0]   wdata_masked;
  logic          ctrl_wr, tx_flush, rx_flush;
  logic          tx_wr_req, tx_full, tx_push, tx_pop;
  logic          rx_rd_req, rx_nonempty, rx_push, rx_pop;
  logic          tx_drop_set, rx_underflow_set;
  logic [31:0]   status;
  logic [1:0]    unused_addr_lsbs;

  assign unused_addr_lsbs = addr[1:0];

  // Bus decode
  assign hit    = ce && (addr[31:4] == BASE_ADDR[31:4]);
  assign bus_wr = hit && we && (sel != 4'b0000);
  assign bus_rd = hit && !we;
  assign rsel   = addr[3:2];

  genvar b;
  generate
    for (b = 0; b < 4; b++) begin : g_byte_mask
      assign wdata_masked[8*b +: 8] = sel[b] ? data_i[8*b +: 8] : 8'h00;
    end
  endgenerate

  assign ctrl_wr  = bus_wr && (rsel == REG_CTRL) && sel[0];
  assign tx_flush = ctrl_wr && data_i[0];
  assign rx_flush = ctrl_wr && data_i[1];

  // TX side: a same-cycle consumer pop never makes room for a full-FIFO push
  assign tx_wr_req   = bus_wr && (rsel == REG_TX);
  assign tx_full     = (tx_count == FULL);
  assign tx_push     = tx_wr_req && !tx_full && !tx_flush;
  assign tx_drop_set = tx_wr_req && tx_full;
  assign tx_pop      = out_valid && out_ready && !tx_flush;

  // RX side: in_ready depends only on the registered count
  assign rx_rd_req        = bus_rd && (rsel == REG_RX);
  assign rx_nonempty      = (rx_count != '0);
  assign rx_pop           = rx_rd_req && rx_nonempty && !rx_flush;
  assign rx_underflow_set = rx_rd_req && !rx_nonempty;
  assign rx_push          = in_valid && in_ready && !rx_flush;

  assign out_valid = (tx_count != '0);
  assign out_data  = tx_mem[tx_rd_ptr];
  assign in_ready  = (rx_count != FULL);
  assign irq       = irq_en && rx_nonempty;

  assign status = {8'(tx_count), 8'(rx_count), 11'b0,
                   irq_en, rx_underflow, tx_drop, tx_full, rx_nonempty};

  always_comb begin
    data_o = 32'h0;
    if (bus_rd) begin
      case (rsel)
        REG_RX:   data_o = rx_nonempty ? rx_mem[rx_rd_ptr] : 32'h0;
        REG_STAT: data_o = status;
        REG_CTRL: data_o = {27'b0, irq_en, 4'b0};
        default:  data_o = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wdata_masked;
    if (rx_push) rx_mem[rx_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr    <= '0;
      tx_rd_ptr    <= '0;
      tx_count     <= '0;
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      rx_count     <= '0;
      tx_drop      <= 1'b0;
      rx_underflow <= 1'b0;
      irq_en       <= 1'b0;
    end else begin
      if (tx_flush) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_count  <= '0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        tx_count <= tx_count + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
      end

      if (rx_flush) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_count  <= '0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        rx_count <= rx_count + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
      end

      // Set wins over a same-cycle write-1-to-clear
      tx_drop      <= tx_drop_set
                      || (tx_drop && !(ctrl_wr && data_i[3]));
      rx_underflow <= rx_underflow_set
                      || (rx_underflow && !(ctrl_wr && data_i[4]));

      if (ctrl_wr) irq_en <= data_i[2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_mailbox
// Purpose  : Directed vector table plus hand-written corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_mailbox;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_CT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i, data_o;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic [31:0] in_data;
  logic        in_valid, in_ready, irq;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mmio_mailbox #(.BASE_ADDR(BASE), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
  );

  typedef struct {
    logic        ce, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic        ordy, ival;
    logic [31:0] idata;
    logic [31:0] e_do;
    logic        e_ov;
    logic [31:0] e_od;
    logic        chk_od;
    logic        e_ir, e_irq;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic c, logic w, logic [31:0] a, logic [3:0] s,
                              logic [31:0] wd, logic ordy, logic ival,
                              logic [31:0] idata, logic [31:0] e_do, logic e_ov,
                              logic [31:0] e_od, logic chk_od, logic e_ir,
                              logic e_irq);
    vec_t v;
    v.ce = c; v.we = w; v.addr = a; v.sel = s; v.wd = wd;
    v.ordy = ordy; v.ival = ival; v.idata = idata;
    v.e_do = e_do; v.e_ov = e_ov; v.e_od = e_od; v.chk_od = chk_od;
    v.e_ir = e_ir; v.e_irq = e_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic bus(input logic c, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    ce = c; we = w; addr = a; sel = s; data_i = d;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, A_TX, 4'h0, 32'h0);
    in_valid = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    bus(1'b1, 1'b0, A_ST, 4'h0, 32'h0);
    @(negedge clk);
    check(name, data_o, exp);
    next();
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus(1'b1, 1'b1, a, s, d);
    next();
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    in_data = 32'h0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- vector table ----------------
    //          ce we addr        sel   wd            ordy ival idata  | data_o      ov  od            chk ir irq
    vt.push_back(mk(0,0,A_TX,      4'h0,32'h0,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,1,A_TX,      4'hF,32'hDEADBEEF, 1,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(0,0,A_TX,      4'h0,32'h0,        1,0,32'h0,      32'h0,       1,32'hDEADBEEF, 1,1,0));
    vt.push_back(mk(0,0,A_TX,      4'h0,32'h0,        1,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,1,A_TX,      4'h3,32'h12345678, 0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,0,A_ST,      4'h0,32'h0,        0,0,32'h0,      32'h01000000,1,32'h00005678, 1,1,0));
    vt.push_back(mk(0,0,A_TX,      4'h0,32'h0,        1,0,32'h0,      32'h0,       1,32'h00005678, 1,1,0));
    vt.push_back(mk(1,0,A_TX,      4'h0,32'h0,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,1,A_CT,      4'h1,32'h4,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,0,A_CT,      4'h0,32'h0,        0,0,32'h0,      32'h10,      0,32'h0,        0,1,0));
    vt.push_back(mk(0,0,A_TX,      4'h0,32'h0,        0,1,32'hA1,     32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(0,0,A_TX,      4'h0,32'h0,        0,1,32'hA2,     32'h0,       0,32'h0,        0,1,1));
    vt.push_back(mk(1,0,A_ST,      4'h0,32'h0,        0,0,32'h0,      32'h00020011,0,32'h0,        0,1,1));
    vt.push_back(mk(1,0,A_RX,      4'h0,32'h0,        0,0,32'h0,      32'hA1,      0,32'h0,        0,1,1));
    vt.push_back(mk(1,0,A_RX,      4'h0,32'h0,        0,0,32'h0,      32'hA2,      0,32'h0,        0,1,1));
    vt.push_back(mk(0,0,A_TX,      4'h0,32'h0,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,0,A_RX,      4'h0,32'h0,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,0,A_ST,      4'h0,32'h0,        0,0,32'h0,      32'h00000018,0,32'h0,        0,1,0));
    vt.push_back(mk(1,1,A_CT,      4'h1,32'h14,       0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,0,A_ST,      4'h0,32'h0,        0,0,32'h0,      32'h00000010,0,32'h0,        0,1,0));
    vt.push_back(mk(1,0,32'h2008,  4'h0,32'h0,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,1,A_CT,      4'h0,32'h0,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,1,A_CT,      4'hE,32'h0,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));
    vt.push_back(mk(1,0,A_ST,      4'h0,32'h0,        0,0,32'h0,      32'h00000010,0,32'h0,        0,1,0));
    vt.push_back(mk(0,0,A_ST,      4'h0,32'h0,        0,0,32'h0,      32'h0,       0,32'h0,        0,1,0));

    foreach (vt[i]) begin
      bus(vt[i].ce, vt[i].we, vt[i].addr, vt[i].sel, vt[i].wd);
      out_ready = vt[i].ordy;
      in_valid  = vt[i].ival;
      in_data   = vt[i].idata;
      @(negedge clk);
      check($sformatf("v%0d data_o", i), data_o, vt[i].e_do);
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      if (vt[i].chk_od) check($sformatf("v%0d out_data", i), out_data, vt[i].e_od);
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      check($sformatf("v%0d irq", i), 32'(irq), 32'(vt[i].e_irq));
      next();
    end
    idle();
    out_ready = 1'b0;

    // ---------------- TX overflow and drop ----------------
    wr(A_CT, 4'h1, 32'h0);
    for (int i = 0; i < 9; i++) wr(A_TX, 4'hF, 32'h100 + i);
    rd_status("tx full status", 32'h08000006);
    out_ready = 1'b1;
    bus(1'b1, 1'b1, A_TX, 4'hF, 32'h999);
    @(negedge clk);
    check("full pop head", out_data, 32'h100);
    next();
    out_ready = 1'b0;
    rd_status("tx full pop no room", 32'h07000004);
    idle();
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d valid", i), 32'(out_valid), 32'h1);
      check($sformatf("drain%0d data", i), out_data, 32'h100 + i);
      next();
    end
    @(negedge clk);
    check("drain empty", 32'(out_valid), 32'h0);
    out_ready = 1'b0;
    wr(A_CT, 4'h1, 32'h08);
    rd_status("tx_drop cleared", 32'h0);

    // ---------------- RX simultaneous push/pop, fill, async reset ----------------
    idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hB1 + i;
      next();
    end
    bus(1'b1, 1'b0, A_RX, 4'h0, 32'h0);
    in_data = 32'hB4;
    @(negedge clk);
    check("rx push+pop head", data_o, 32'hB1);
    next();
    in_valid = 1'b0;
    rd_status("rx count held", 32'h00030001);
    wr(A_CT, 4'h1, 32'h04);
    idle();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'hC0 + i;
      @(negedge clk);
      check($sformatf("fill%0d in_ready", i), 32'(in_ready), 32'h1);
      next();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rx full in_ready", 32'(in_ready), 32'h0);
    check("rx full irq", 32'(irq), 32'h1);
    rd_status("rx full status", 32'h00080011);
    bus(1'b1, 1'b0, A_RX, 4'h0, 32'h0);
    in_valid = 1'b1; in_data = 32'hEE;
    @(negedge clk);
    check("full pop head", data_o, 32'hB2);
    check("full pop in_ready", 32'(in_ready), 32'h0);
    next();
    in_valid = 1'b0;
    rd_status("no push while full", 32'h00070011);
    in_valid = 1'b1; in_data = 32'hFF;
    wr(A_TX, 4'hF, 32'h55);
    in_valid = 1'b0;
    bus(1'b1, 1'b0, A_ST, 4'h0, 32'h0);
    @(negedge clk);
    check("pre-reset status", data_o, 32'h01080011);
    check("pre-reset out_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst in_ready", 32'(in_ready), 32'h1);
    check("async rst irq", 32'(irq), 32'h0);
    check("async rst out_valid", 32'(out_valid), 32'h0);
    check("async rst status", data_o, 32'h0);
    next();
    rst = 1'b0;
    rd_status("post-reset status", 32'h0);

    // ---------------- flush priority ----------------
    wr(A_TX, 4'hF, 32'h61);
    wr(A_TX, 4'hF, 32'h62);
    out_ready = 1'b1;
    bus(1'b1, 1'b1, A_CT, 4'h1, 32'h01);
    @(negedge clk);
    check("flush-cycle head", out_data, 32'h61);
    next();
    out_ready = 1'b0;
    @(negedge clk);
    check("tx flushed valid", 32'(out_valid), 32'h0);
    rd_status("tx flushed status", 32'h0);
    idle();
    in_valid = 1'b1; in_data = 32'hD1; next();
    in_data = 32'hD2; next();
    in_data = 32'hD3;
    bus(1'b1, 1'b1, A_CT, 4'h1, 32'h02);
    next();
    in_valid = 1'b0;
    rd_status("rx flushed status", 32'h0);
    bus(1'b1, 1'b0, A_RX, 4'h0, 32'h0);
    @(negedge clk);
    check("rx flushed read", data_o, 32'h0);
    next();
    rd_status("underflow after flush", 32'h00000008);

    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
